// File: rtl/mem_stage.sv
// Memory-access stage: turns the EX result into a data-memory request or a
// direct writeback, and emits one registered writeback record per instruction.
module mem_stage #(
  parameter int unsigned XLEN           = 32,
  parameter bit          MISALIGN_CHECK = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] alu_result,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_addr,
  input  logic [2:0]      funct3,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  output logic            dmem_req_valid,
  input  logic            dmem_req_ready,
  output logic [XLEN-1:0] dmem_addr,
  output logic            dmem_we,
  output logic [3:0]      dmem_wstrb,
  output logic [XLEN-1:0] dmem_wdata,
  input  logic            dmem_rsp_valid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            wb_valid,
  output logic [4:0]      wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            wb_reg_write,
  output logic            misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_RSP} state_t;

  state_t      r_state;
  logic [1:0]  r_lane;
  logic [2:0]  r_funct3;
  logic [4:0]  r_rd;
  logic        r_reg_write;
  logic        r_is_load;

  logic            w_accept;
  logic            w_is_mem;
  logic            w_misalign;
  logic [3:0]      w_wstrb;
  logic [XLEN-1:0] w_wdata;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;

  assign in_ready = (r_state == IDLE);
  assign w_accept = in_valid && in_ready;
  assign w_is_mem = mem_read || mem_write;

  // funct3[1:0] selects width; encodings 011/110/111 fall through to word.
  always_comb begin
    w_misalign = 1'b0;
    w_wstrb    = 4'b1111;
    w_wdata    = rs2_data;
    case (funct3[1:0])
      2'b00: begin
        w_wstrb = 4'b0001 << alu_result[1:0];
        w_wdata = {4{rs2_data[7:0]}};
      end
      2'b01: begin
        w_misalign = alu_result[0];
        w_wstrb    = alu_result[1] ? 4'b1100 : 4'b0011;
        w_wdata    = {2{rs2_data[15:0]}};
      end
      default: w_misalign = |alu_result[1:0];
    endcase
    if (!MISALIGN_CHECK) w_misalign = 1'b0;
  end

  always_comb begin
    case (r_lane)
      2'd0:    w_byte = dmem_rdata[7:0];
      2'd1:    w_byte = dmem_rdata[15:8];
      2'd2:    w_byte = dmem_rdata[23:16];
      default: w_byte = dmem_rdata[31:24];
    endcase
    w_half = r_lane[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    case (r_funct3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b100:  w_load = {24'd0, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = dmem_rdata;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= IDLE;
      r_lane         <= '0;
      r_funct3       <= '0;
      r_rd           <= '0;
      r_reg_write    <= 1'b0;
      r_is_load      <= 1'b0;
      dmem_req_valid <= 1'b0;
      dmem_addr      <= '0;
      dmem_we        <= 1'b0;
      dmem_wstrb     <= '0;
      dmem_wdata     <= '0;
      wb_valid       <= 1'b0;
      wb_rd          <= '0;
      wb_data        <= '0;
      wb_reg_write   <= 1'b0;
      misalign       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      misalign <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_lane      <= alu_result[1:0];
            r_funct3    <= funct3;
            r_rd        <= rd_addr;
            r_reg_write <= reg_write;
            r_is_load   <= mem_read;
            if (!w_is_mem) begin
              wb_valid     <= 1'b1;
              wb_rd        <= rd_addr;
              wb_data      <= alu_result;
              wb_reg_write <= reg_write;
            end else if (w_misalign) begin
              wb_valid     <= 1'b1;
              wb_rd        <= rd_addr;
              wb_data      <= '0;
              wb_reg_write <= 1'b0;
              misalign     <= 1'b1;
            end else begin
              r_state        <= REQ;
              dmem_req_valid <= 1'b1;
              dmem_addr      <= {alu_result[XLEN-1:2], 2'b00};
              dmem_we        <= mem_write;
              dmem_wstrb     <= w_wstrb;
              dmem_wdata     <= w_wdata;
            end
          end
        end
        REQ: begin
          if (dmem_req_ready) begin
            dmem_req_valid <= 1'b0;
            if (r_is_load) begin
              r_state <= WAIT_RSP;
            end else begin
              r_state      <= IDLE;
              wb_valid     <= 1'b1;
              wb_rd        <= r_rd;
              wb_data      <= '0;
              wb_reg_write <= 1'b0;
            end
          end
        end
        WAIT_RSP: begin
          if (dmem_rsp_valid) begin
            r_state      <= IDLE;
            wb_valid     <= 1'b1;
            wb_rd        <= r_rd;
            wb_data      <= w_load;
            wb_reg_write <= r_reg_write;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: byte-array memory model, randomized memory
// timing with spurious responses, and a decoupled writeback monitor.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid, in_ready;
  logic [31:0] alu_result, rs2_data;
  logic [4:0]  rd_addr;
  logic [2:0]  funct3;
  logic        mem_read, mem_write, reg_write;
  logic        dmem_req_valid, dmem_req_ready, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_wstrb;
  logic        dmem_rsp_valid;
  logic        wb_valid, wb_reg_write, misalign;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;

  mem_stage #(.XLEN(32), .MISALIGN_CHECK(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .alu_result(alu_result), .rs2_data(rs2_data), .rd_addr(rd_addr),
    .funct3(funct3), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .dmem_req_valid(dmem_req_valid),
    .dmem_req_ready(dmem_req_ready), .dmem_addr(dmem_addr), .dmem_we(dmem_we),
    .dmem_wstrb(dmem_wstrb), .dmem_wdata(dmem_wdata),
    .dmem_rsp_valid(dmem_rsp_valid), .dmem_rdata(dmem_rdata),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .wb_reg_write(wb_reg_write), .misalign(misalign)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic        rw;
    logic        mis;
    logic        chk_data;
    int          cyc;
  } wb_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  strb;
    logic [31:0] wdata;
  } req_t;

  wb_t         wbq[$];
  req_t        reqq[$];
  logic [7:0]  mem_b [0:1023];
  logic [31:0] mem_w [0:255];
  int          passed = 0;
  int          total = 0;
  int          cyc = 0;
  int          req_stall_cfg = -1;
  int          rsp_cfg = -1;
  int          rsp_cnt = 0;
  logic        stale = 1'b0;

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [31:0] init_word(input int unsigned i);
    return (i * 32'h9E3779B9) ^ 32'h5A5AC3C3;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Reference: byte-addressed memory, size from funct3, alignment by modulo.
  task automatic model(input int unsigned kind, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic rw);
    int unsigned sz, off, base;
    wb_t         e;
    req_t        r;
    logic [31:0] v, mask;
    sz   = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    off  = a % 4;
    base = a % 1024;
    e.rd = rd; e.data = '0; e.rw = 1'b0; e.mis = 1'b0; e.chk_data = 1'b0; e.cyc = -1;
    if (kind == 0) begin
      e.data = a; e.rw = rw; e.chk_data = 1'b1; e.cyc = cyc;
    end else if ((a % sz) != 0) begin
      e.mis = 1'b1; e.cyc = cyc;
    end else begin
      r.addr  = a - off;
      r.we    = (kind == 2);
      r.strb  = 4'(((1 << sz) - 1) << off);
      r.wdata = (sz == 1) ? rs2[7:0] * 32'h01010101 :
                (sz == 2) ? rs2[15:0] * 32'h00010001 : rs2;
      if (kind == 2) begin
        for (int unsigned i = 0; i < sz; i++) mem_b[10'(base + i)] = rs2[8*i +: 8];
      end else begin
        v = '0;
        for (int unsigned i = 0; i < sz; i++) v = v | (32'(mem_b[10'(base + i)]) << (8 * i));
        mask = (sz == 4) ? '1 : (32'd1 << (8 * sz)) - 32'd1;
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | ~mask;
        e.data = v; e.rw = rw; e.chk_data = 1'b1;
      end
      reqq.push_back(r);
    end
    wbq.push_back(e);
  endtask

  task automatic issue(input int unsigned kind, input logic [31:0] a, input logic [31:0] rs2,
                       input logic [4:0] rd, input logic [2:0] f3, input logic rw,
                       output int unsigned waited);
    @(negedge clk);
    in_valid = 1'b1; alu_result = a; rs2_data = rs2; rd_addr = rd; funct3 = f3;
    mem_read = (kind == 1); mem_write = (kind == 2); reg_write = rw;
    waited = 0;
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      chk("in_ready_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model(kind, a, rs2, rd, f3, rw);
  endtask

  task automatic drain();
    int unsigned n = 0;
    while ((wbq.size() > 0 || reqq.size() > 0) && n < 300) begin
      @(posedge clk);
      #2;
      n++;
    end
    chk("drain_wb", 32'(wbq.size()), 32'd0);
  endtask

  // Writeback monitor
  initial forever begin
    wb_t e;
    @(negedge clk);
    if (!rst) begin
      if (wb_valid) begin
        if (wbq.size() == 0) begin
          chk("wb_unexpected", 32'(wb_valid), 32'd0);
        end else begin
          e = wbq.pop_front();
          chk("wb_reg_write", 32'(wb_reg_write), 32'(e.rw));
          chk("wb_misalign", 32'(misalign), 32'(e.mis));
          if (e.chk_data) begin
            chk("wb_rd", 32'(wb_rd), 32'(e.rd));
            chk("wb_data", wb_data, e.data);
          end
          if (e.cyc >= 0) chk("wb_cycle", 32'(cyc), 32'(e.cyc));
        end
      end else if (misalign) begin
        chk("misalign_stray", 32'(misalign), 32'd0);
      end
    end
  end

  // Memory responder: random stalls and latency, junk responses when idle
  initial begin
    req_t        exp_r, hold;
    logic        have = 1'b0;
    logic        just_hs = 1'b0;
    int          stall = 0;
    logic [31:0] rsp_data = '0;
    for (int unsigned i = 0; i < 256; i++) mem_w[i] = init_word(i);
    dmem_req_ready = 1'b0; dmem_rsp_valid = 1'b0; dmem_rdata = '0;
    forever begin
      @(negedge clk);
      dmem_req_ready = 1'b0;
      dmem_rsp_valid = 1'b0;
      dmem_rdata     = $urandom;
      if (rst) begin
        if (rsp_cnt > 0) stale = 1'b1;
        have = 1'b0; just_hs = 1'b0;
      end
      if (just_hs) begin
        chk("req_drop", 32'(dmem_req_valid), 32'd0);
        just_hs = 1'b0;
      end
      if (!rst && !stale && (dmem_req_valid || rsp_cnt > 0))
        chk("in_ready_busy", 32'(in_ready), 32'd0);
      if (rsp_cnt > 0) begin
        rsp_cnt--;
        if (rsp_cnt == 0) begin
          dmem_rsp_valid = 1'b1; dmem_rdata = rsp_data; stale = 1'b0;
        end
      end else if ($urandom_range(0, 4) == 0) begin
        dmem_rsp_valid = 1'b1;
      end
      if (!rst && dmem_req_valid) begin
        if (!have) begin
          if (reqq.size() == 0) begin
            chk("req_unexpected", 32'(dmem_req_valid), 32'd0);
          end else begin
            exp_r = reqq.pop_front();
            chk("req_addr", dmem_addr, exp_r.addr);
            chk("req_we", 32'(dmem_we), 32'(exp_r.we));
            if (exp_r.we) begin
              chk("req_wstrb", 32'(dmem_wstrb), 32'(exp_r.strb));
              chk("req_wdata", dmem_wdata, exp_r.wdata);
            end
          end
          have = 1'b1;
          hold.addr = dmem_addr; hold.we = dmem_we; hold.strb = dmem_wstrb; hold.wdata = dmem_wdata;
          stall = (req_stall_cfg >= 0) ? req_stall_cfg : int'($urandom_range(0, 3));
        end else begin
          chk("hold_addr", dmem_addr, hold.addr);
          chk("hold_we", 32'(dmem_we), 32'(hold.we));
          chk("hold_wstrb", 32'(dmem_wstrb), 32'(hold.strb));
          chk("hold_wdata", dmem_wdata, hold.wdata);
        end
        if (stall == 0) begin
          dmem_req_ready = 1'b1; have = 1'b0; just_hs = 1'b1;
          if (dmem_we) begin
            for (int unsigned i = 0; i < 4; i++)
              if (dmem_wstrb[i]) mem_w[dmem_addr[9:2]][8*i +: 8] = dmem_wdata[8*i +: 8];
          end else begin
            rsp_data = mem_w[dmem_addr[9:2]];
            rsp_cnt  = (rsp_cfg > 0) ? rsp_cfg : 1 + int'($urandom_range(0, 3));
          end
        end else begin
          stall--;
        end
      end
    end
  end

  // Stimulus
  initial begin
    int unsigned w, kind;
    logic [31:0] a, t;
    for (int unsigned i = 0; i < 1024; i++) begin
      t = init_word(i / 4);
      mem_b[i] = t[8*(i%4) +: 8];
    end
    in_valid = 1'b0; alu_result = '0; rs2_data = '0; rd_addr = '0; funct3 = '0;
    mem_read = 1'b0; mem_write = 1'b0; reg_write = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_wb_valid", 32'(wb_valid), 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    chk("rst_wb_rd", 32'(wb_rd), 32'd0);
    chk("rst_wb_reg_write", 32'(wb_reg_write), 32'd0);
    chk("rst_misalign", 32'(misalign), 32'd0);
    chk("rst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("rst_addr", dmem_addr, 32'd0);
    chk("rst_we_strb", {27'd0, dmem_we, dmem_wstrb}, 32'd0);
    chk("rst_wdata", dmem_wdata, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Back-to-back ALU ops
    issue(0, 32'd5, '0, 5'd1, 3'b000, 1'b1, w);
    issue(0, 32'd6, '0, 5'd2, 3'b000, 1'b1, w);
    chk("alu_b2b_wait2", 32'(w), 32'd0);
    issue(0, 32'd7, '0, 5'd3, 3'b000, 1'b1, w);
    chk("alu_b2b_wait3", 32'(w), 32'd0);
    drain();

    // SB with two stall cycles on the request
    req_stall_cfg = 2;
    issue(2, 32'h1003, 32'h000000A5, 5'd9, 3'b000, 1'b1, w);
    drain();
    req_stall_cfg = 0;

    // Byte loads with response three cycles after the handshake
    issue(2, 32'h2000, 32'h0080FF11, 5'd0, 3'b010, 1'b0, w);
    drain();
    rsp_cfg = 3;
    issue(1, 32'h2002, '0, 5'd10, 3'b000, 1'b1, w);
    issue(1, 32'h2002, '0, 5'd11, 3'b100, 1'b1, w);
    drain();

    // Half loads
    issue(2, 32'h2000, 32'h80011234, 5'd0, 3'b010, 1'b0, w);
    issue(1, 32'h2002, '0, 5'd12, 3'b001, 1'b1, w);
    issue(1, 32'h2000, '0, 5'd13, 3'b101, 1'b1, w);
    drain();

    // Misaligned word load
    issue(1, 32'h3001, '0, 5'd14, 3'b010, 1'b1, w);
    drain();

    // Reset while waiting for a load response; the late response must be ignored
    rsp_cfg = 8;
    issue(1, 32'h0100, '0, 5'd15, 3'b010, 1'b1, w);
    for (int unsigned n = 0; n < 50 && rsp_cnt == 0; n++) begin
      @(posedge clk);
      #2;
    end
    chk("reset_test_in_wait", 32'(rsp_cnt > 0), 32'd1);
    rst = 1'b1;
    wbq.delete();
    @(posedge clk);
    #1;
    chk("midrst_wb_valid", 32'(wb_valid), 32'd0);
    chk("midrst_req_valid", 32'(dmem_req_valid), 32'd0);
    chk("midrst_wb_data", wb_data, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("in_ready_after_midrst", 32'(in_ready), 32'd1);
    repeat (12) @(posedge clk);
    #1;
    chk("stale_rsp_consumed", 32'(stale), 32'd0);
    rsp_cfg = -1;
    req_stall_cfg = -1;

    // Randomized mix, including unsupported funct3 encodings
    for (int unsigned n = 0; n < 200; n++) begin
      kind = $urandom_range(0, 2);
      a = (kind == 0) ? $urandom : 32'($urandom_range(0, 1023));
      if (kind != 0 && $urandom_range(0, 1) == 0) a = a & ~32'd3;
      issue(kind, a, $urandom, 5'($urandom), 3'($urandom), 1'($urandom), w);
    end
    drain();
    chk("drain_req", 32'(reqq.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the EX ALU.
- Consumes the ALU result as the effective address (loads/stores) or as the writeback value (ALU ops).
- Drives a valid/ready data-memory port and produces one registered writeback record per accepted instruction.
- Stalls EX via `in_ready` while a memory transaction is outstanding.

Parameters:
- XLEN, 32: datapath width. Only 32 is supported.
- MISALIGN_CHECK, 1: 1 = detect misaligned accesses and suppress them; 0 = issue them with the low address bits ignored.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous reset, active-high
- in_valid  in  1  EX presents an instruction
- in_ready  out  1  stage can accept an instruction this cycle
- alu_result  in  32  ALU output (address or result)
- rs2_data  in  32  store data
- rd_addr  in  5  destination register
- funct3  in  3  access size/sign: 000 LB/SB, 001 LH/SH, 010 LW/SW, 100 LBU, 101 LHU
- mem_read  in  1  load
- mem_write  in  1  store; mem_read and mem_write are never both 1
- reg_write  in  1  instruction writes rd
- dmem_req_valid  out  1  memory request
- dmem_req_ready  in  1  memory accepts request
- dmem_addr  out  32  word-aligned address ({alu_result[31:2],2'b00})
- dmem_we  out  1  1 = write
- dmem_wstrb  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rsp_valid  in  1  read data valid
- dmem_rdata  in  32  read data word
- wb_valid  out  1  writeback record valid (one-cycle pulse per instruction)
- wb_rd  out  5  writeback register
- wb_data  out  32  writeback value
- wb_reg_write  out  1  commit enable for rd
- misalign  out  1  one-cycle pulse coincident with wb_valid for a misaligned access

Behaviour:
- Reset:
  - state = IDLE.
  - All outputs 0: wb_*, misalign, dmem_req_valid, dmem_we, dmem_wstrb, dmem_addr, dmem_wdata.
  - in_ready = 1 in the cycle after reset deasserts.
  - Reset mid-transaction abandons it; any later dmem_rsp_valid is ignored.
- `in_ready` = (state == IDLE). An instruction is accepted when in_valid && in_ready. All inputs are captured into internal registers on acceptance.
- FSM states: IDLE, REQ, WAIT_RSP.
- IDLE, accepted non-memory op:
  - Next cycle: wb_valid=1, wb_data=alu_result, wb_rd=rd_addr, wb_reg_write=reg_write.
  - Stay in IDLE. Back-to-back ALU ops sustain 1 per cycle.
- IDLE, accepted memory op:
  - Misaligned (MISALIGN_CHECK=1) means half with addr[0]=1, or word with addr[1:0]!=0. No request is issued. Next cycle: wb_valid=1, wb_reg_write=0, misalign=1. Stay in IDLE.
  - Otherwise go to REQ.
- REQ:
  - dmem_req_valid=1; addr, we, wstrb, wdata are held stable until dmem_req_ready.
  - On ready, a store completes: the following cycle wb_valid=1 with wb_reg_write=0, and the FSM returns to IDLE.
  - On ready, a load goes to WAIT_RSP. The request drops the cycle after the handshake.
- WAIT_RSP:
  - Wait for dmem_rsp_valid; the earliest response is the cycle after the request handshake.
  - On response, extract the lane, extend it, register it to wb_data. The next cycle has wb_valid=1, wb_reg_write=reg_write. Return to IDLE.
  - dmem_rsp_valid in IDLE or REQ is ignored.
- Store lanes:
  - SB: wstrb = 1<<addr[1:0], wdata = {4{rs2[7:0]}}.
  - SH: wstrb = 0011 (addr[1]=0) or 1100 (addr[1]=1), wdata = {2{rs2[15:0]}}.
  - SW: wstrb = 1111, wdata = rs2.
- Load extraction:
  - Byte = rdata[8*addr[1:0] +: 8].
  - Half = rdata[16*addr[1] +: 16].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- Load latency from acceptance: 1 cycle to REQ, + N cycles of req stall, + M cycles of response wait, + 1 cycle to wb_valid.
- Unsupported funct3 on a memory op: treated as LW width for alignment and strobes (wstrb=1111; a load's writeback is the full word).
- wb_valid is a single-cycle pulse. Writeback has no backpressure.

Test Plan:
- ALU pass-through: three back-to-back in_valid ALU ops, alu_result 5, 6, 7, rd 1, 2, 3 -> wb_valid on three consecutive cycles carrying (1,5), (2,6), (3,7); in_ready stays 1.
- SB at 0x1003, rs2=0x000000A5, dmem_req_ready delayed 2 cycles -> dmem_addr=0x1000, wstrb=1000, wdata=0xA5A5A5A5, all held stable for 3 cycles; wb_valid with wb_reg_write=0.
- LB at 0x2002, rdata=0x0080FF11, rsp 3 cycles after handshake -> wb_data=0xFFFFFF80. The same access with LBU -> 0x00000080. in_ready=0 throughout the transaction.
- LH at 0x2002, rdata=0x8001_1234 -> wb_data=0xFFFF8001. LHU at 0x2000 on the same rdata -> 0x00001234.
- Misaligned LW at 0x3001 -> no dmem_req_valid; next cycle wb_valid=1, misalign=1, wb_reg_write=0.
- rst asserted while in WAIT_RSP, then dmem_rsp_valid pulsed -> all outputs 0, no wb_valid, in_ready=1 after reset.
